axi_sram_responder: RTL and testbench

AXI4 slave endpoint that terminates one interconnect master port and converts bursts into single-port SRAM accesses. It is the responder end of the node's master ports, placed behind a master-side slice. Reads and writes are serialised onto one SRAM port. FIXED, INCR and WRAP bursts are supported. The read path has a 2-entry buffer so that back-pressure on R never loses SRAM data.

---
 rtl/axi_sram_pkg.sv | 48 ++++
 rtl/axi_sram_responder_if.sv | 70 +++++++
 rtl/axi_sram_addr_gen.sv | 63 ++++++
 rtl/axi_sram_responder.sv | 204 ++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types, encodings and the burst address step for the AXI-to-SRAM responder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axi_sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Address arithmetic is done at this width and truncated by the caller.
    localparam int unsigned CALC_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        BRESP = 2'd2,
        READ  = 2'd3
    } state_t;

    // Address of the beat following 'addr' within a burst.
    function automatic logic [CALC_W-1:0] next_beat_addr(
        input logic [CALC_W-1:0] addr,
        input logic [2:0]        size,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [CALC_W-1:0] bytes;
        logic [CALC_W-1:0] incr;
        logic [CALC_W-1:0] wsize;
        logic [CALC_W-1:0] base;
        bytes = 64'd1 << size;
        incr  = (addr & ~(bytes - 64'd1)) + bytes;
        // Wrap window is (len+1) beats, aligned to its own size.
        wsize = ({56'd0, len} + 64'd1) << size;
        base  = addr & ~(wsize - 64'd1);
        if (burst == BURST_FIXED) begin
            return addr;
        end
        if (burst == BURST_WRAP && incr == base + wsize) begin
            return base;
        end
        return incr;
    endfunction

endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI4 channel bundle between an interconnect master port and the SRAM responder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every channel; slave modport drives the readies and B/R.
interface axi_sram_responder_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 6,
    parameter int AXI_USER_W = 6
);
    localparam int NB = AXI_DATA_W / 8;

    logic                  aw_valid, aw_ready;
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic [AXI_USER_W-1:0] aw_user;

    logic                  w_valid, w_ready;
    logic [AXI_DATA_W-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic                  w_last;

    logic                  b_valid, b_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [AXI_USER_W-1:0] b_user;

    logic                  ar_valid, ar_ready;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic [AXI_USER_W-1:0] ar_user;

    logic                  r_valid, r_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [AXI_USER_W-1:0] r_user;

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );
endinterface

// File: rtl/axi_sram_addr_gen.sv
// Burst address/beat tracker shared by the read and write paths.
// Latency: new address visible the cycle after load/adv.
// Backpressure: none; advances only when the owner pulses adv.
// Ports: load + ld_* capture a burst; adv steps one beat; addr/last describe the current beat.
module axi_sram_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_len,
    input  logic [2:0]        ld_size,
    input  logic [1:0]        ld_burst,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [7:0]        beat_q, beat_d;

    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        if (load) begin
            addr_d  = ld_addr;
            len_d   = ld_len;
            size_d  = ld_size;
            burst_d = ld_burst;
            beat_d  = 8'd0;
        end else if (adv) begin
            addr_d = ADDR_W'(next_beat_addr(CALC_W'(addr_q), size_q, len_q, burst_q));
            beat_d = beat_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end

    assign addr = addr_q;
    assign last = (beat_q == len_q);
endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave that serialises AW/W and AR bursts onto one single-port SRAM, with a 2-entry R buffer.
// Latency: B valid 1 cycle after last W; first R valid 2 cycles after AR handshake; 1 R beat/cycle.
// Backpressure: SRAM reads issue only while in-flight + buffered < 2, so a stalled R never drops data.
// Ports: clk/rst_n; axi (slave modport: AW/W/B/AR/R); mem_* single-port SRAM (rdata 1 cycle after req).
module axi_sram_responder
    import axi_sram_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 6,
    parameter int AXI_USER_W = 6,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axi_sram_responder_if.slave     axi,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [MEM_ADDR_W-1:0]   mem_addr,
    output logic [AXI_DATA_W/8-1:0] mem_be,
    output logic [AXI_DATA_W-1:0]   mem_wdata,
    input  logic [AXI_DATA_W-1:0]   mem_rdata
);
    localparam int NB  = AXI_DATA_W / 8;
    localparam int OFS = $clog2(NB);

    state_t                state_q, state_d;
    logic                  run_q;              // low through reset, so no ready is offered early
    logic                  rr_q, rr_d;         // 0: write wins the next AW/AR collision
    logic                  err_q, err_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [AXI_USER_W-1:0] user_q, user_d;
    logic                  rd_done_q, rd_done_d;  // every read beat of the burst has been issued
    logic                  inflight_q, inflight_d;
    logic                  pend_last_q, pend_last_d;
    logic [AXI_DATA_W-1:0] fdat0_q, fdat0_d, fdat1_q, fdat1_d;
    logic                  flast0_q, flast0_d, flast1_q, flast1_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  aw_hs, ar_hs, w_hs, pop, rd_issue, beat_last;
    logic [AXI_ADDR_W-1:0] c_addr, cur_addr;
    logic [7:0]            c_len;
    logic [2:0]            c_size;
    logic [1:0]            c_burst;
    logic                  c_err;
    logic [2:0]            occ;
    logic                  unused_addr_bits;

    // The ready of the losing channel stays low while both are valid.
    assign axi.aw_ready = run_q && state_q == IDLE && (!axi.ar_valid || !rr_q);
    assign axi.ar_ready = run_q && state_q == IDLE && (!axi.aw_valid ||  rr_q);
    assign aw_hs = axi.aw_valid && axi.aw_ready;
    assign ar_hs = axi.ar_valid && axi.ar_ready;

    assign c_addr  = aw_hs ? axi.aw_addr  : axi.ar_addr;
    assign c_len   = aw_hs ? axi.aw_len   : axi.ar_len;
    assign c_size  = aw_hs ? axi.aw_size  : axi.ar_size;
    assign c_burst = aw_hs ? axi.aw_burst : axi.ar_burst;
    assign c_err   = (c_size > 3'(OFS)) || (c_burst == 2'b11) ||
                     (c_burst == BURST_WRAP && !(c_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    assign axi.w_ready = (state_q == WRITE);
    assign w_hs        = (state_q == WRITE) && axi.w_valid;

    assign axi.b_valid = (state_q == BRESP);
    assign axi.b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi.b_id    = id_q;
    assign axi.b_user  = user_q;

    assign axi.r_valid = (cnt_q != 2'd0);
    assign axi.r_data  = fdat0_q;
    assign axi.r_last  = flast0_q;
    assign axi.r_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi.r_id    = id_q;
    assign axi.r_user  = user_q;
    assign pop         = axi.r_valid && axi.r_ready;

    // A slot freed by this cycle's pop counts as available credit.
    assign occ      = {2'b0, inflight_q} + {1'b0, cnt_q};
    assign rd_issue = (state_q == READ) && !rd_done_q && (occ < 3'd2 + {2'b0, pop});

    axi_sram_addr_gen #(.ADDR_W(AXI_ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (aw_hs || ar_hs),
        .ld_addr  (c_addr),
        .ld_len   (c_len),
        .ld_size  (c_size),
        .ld_burst (c_burst),
        .adv      (w_hs || rd_issue),
        .addr     (cur_addr),
        .last     (beat_last)
    );

    // Errored bursts still walk their beats, just without touching the SRAM.
    assign mem_req   = (w_hs || rd_issue) && !err_q;
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = cur_addr[MEM_ADDR_W+OFS-1:OFS];
    assign mem_be    = mem_we ? axi.w_strb : '1;
    assign mem_wdata = axi.w_data;
    assign unused_addr_bits = ^cur_addr;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        err_d       = err_q;
        id_d        = id_q;
        user_d      = user_q;
        rd_done_d   = rd_done_q;
        inflight_d  = rd_issue;
        pend_last_d = pend_last_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d = WRITE;
                    id_d    = axi.aw_id;
                    user_d  = axi.aw_user;
                    err_d   = c_err;
                    if (axi.ar_valid) rr_d = ~rr_q;
                end else if (ar_hs) begin
                    state_d   = READ;
                    id_d      = axi.ar_id;
                    user_d    = axi.ar_user;
                    err_d     = c_err;
                    rd_done_d = 1'b0;
                    if (axi.aw_valid) rr_d = ~rr_q;
                end
            end
            WRITE: begin
                if (w_hs) begin
                    if (axi.w_last != beat_last) err_d = 1'b1;
                    if (beat_last) state_d = BRESP;
                end
            end
            BRESP: begin
                if (axi.b_ready) state_d = IDLE;
            end
            READ: begin
                if (rd_issue) begin
                    pend_last_d = beat_last;
                    if (beat_last) rd_done_d = 1'b1;
                end
                if (pop && flast0_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry R buffer; entry 0 is the head presented on R.
    always_comb begin
        fdat0_d  = fdat0_q;
        fdat1_d  = fdat1_q;
        flast0_d = flast0_q;
        flast1_d = flast1_q;
        cnt_d    = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        if (pop) begin
            fdat0_d  = fdat1_q;
            flast0_d = flast1_q;
        end
        if (inflight_q) begin
            if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
                fdat0_d  = err_q ? '0 : mem_rdata;
                flast0_d = pend_last_q;
            end else begin
                fdat1_d  = err_q ? '0 : mem_rdata;
                flast1_d = pend_last_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            rr_q        <= 1'b0;
            err_q       <= 1'b0;
            id_q        <= '0;
            user_q      <= '0;
            rd_done_q   <= 1'b0;
            inflight_q  <= 1'b0;
            pend_last_q <= 1'b0;
            fdat0_q     <= '0;
            fdat1_q     <= '0;
            flast0_q    <= 1'b0;
            flast1_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            rr_q        <= rr_d;
            err_q       <= err_d;
            id_q        <= id_d;
            user_q      <= user_d;
            rd_done_q   <= rd_done_d;
            inflight_q  <= inflight_d;
            pend_last_q <= pend_last_d;
            fdat0_q     <= fdat0_d;
            fdat1_q     <= fdat1_d;
            flast0_q    <= flast0_d;
            flast1_q    <= flast1_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
module tb_axi_sram_responder;
    import axi_sram_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_sram_responder_if bus ();

    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata, mem_rdata;

    axi_sram_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .axi       (bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // SRAM model: read data one cycle after the request.
    logic [63:0] mem [0:1023];
    logic [9:0]  rd_log[$];
    logic [9:0]  wr_log[$];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                wr_log.push_back(mem_addr);
            end else begin
                mem_rdata <= mem[mem_addr];
                rd_log.push_back(mem_addr);
            end
        end
    end

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] r_q[$];
    logic [63:0] wd[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic do_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user);
        int n;
        @(negedge clk);
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
        bus.aw_size = size; bus.aw_burst = burst; bus.aw_user = user; bus.aw_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.aw_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("aw_handshake", 64'(bus.aw_ready), 64'd1);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
    endtask

    task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user);
        int n;
        @(negedge clk);
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
        bus.ar_size = size; bus.ar_burst = burst; bus.ar_user = user; bus.ar_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.ar_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("ar_handshake", 64'(bus.ar_ready), 64'd1);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        input logic exp_req);
        int n;
        @(negedge clk);
        bus.w_data = data; bus.w_strb = strb; bus.w_last = last; bus.w_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.w_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("w_ready", 64'(bus.w_ready), 64'd1);
        chk("w_mem_req", 64'(mem_req), 64'(exp_req));
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp, input logic [5:0] id, input logic [5:0] user);
        int n;
        @(negedge clk); #1;
        n = 0;
        while (!bus.b_valid && n < 50) begin @(negedge clk); #1; n++; end
        chk("b_valid", 64'(bus.b_valid), 64'd1);
        chk("b_resp", 64'(bus.b_resp), 64'(resp));
        chk("b_id", 64'(bus.b_id), 64'(id));
        chk("b_user", 64'(bus.b_user), 64'(user));
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
    endtask

    // Accepts n R beats; r_ready is raised only at a sample point so no beat goes unrecorded.
    task automatic collect_r(input int n, input int last_idx, input logic [5:0] id,
                             input logic [5:0] user, input logic [1:0] resp, output int cyc);
        int got;
        r_q.delete();
        got = 0;
        cyc = 0;
        while (got < n && cyc < 100) begin
            @(negedge clk);
            bus.r_ready = 1'b1;
            #1;
            cyc++;
            if (bus.r_valid) begin
                r_q.push_back(bus.r_data);
                chk("r_last", 64'(bus.r_last), 64'(got == last_idx));
                chk("r_id", 64'(bus.r_id), 64'(id));
                chk("r_user", 64'(bus.r_user), 64'(user));
                chk("r_resp", 64'(bus.r_resp), 64'(resp));
                got++;
            end
        end
        chk("r_beats", 64'(got), 64'(n));
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
    endtask

    initial begin
        int issues;
        int cyc;
        logic [9:0] wrap_exp[4];
        wrap_exp = '{10'h23, 10'h20, 10'h21, 10'h22};
        for (int i = 0; i < 4; i++) wd[i] = 64'h0123_4567_89AB_0000 + 64'(i) * 64'h1111;

        bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.aw_size = '0; bus.aw_burst = '0; bus.aw_user = '0;
        bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.ar_size = '0; bus.ar_burst = '0; bus.ar_user = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // INCR write of 4 beats to 0x100 -> words 0x20..0x23.
        wr_log.delete();
        do_aw(6'd5, 32'h100, 8'd3, 3'd3, BURST_INCR, 6'd3);
        for (int i = 0; i < 4; i++) do_w(wd[i], 8'hFF, i == 3, 1'b1);
        chk("b_one_cycle_after_last_w", 64'(bus.b_valid), 64'd1);
        do_b(RESP_OKAY, 6'd5, 6'd3);
        chk("wr_count", 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", 64'(wr_log[i]), 64'h20 + 64'(i));
            chk("wr_data", mem[10'h20 + 10'(i)], wd[i]);
        end

        // FIXED burst to one word; the second beat only updates the low bytes.
        wr_log.delete();
        do_aw(6'd6, 32'h40, 8'd1, 3'd3, BURST_FIXED, 6'd0);
        do_w(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0, 1'b1);
        do_w(64'h1111_2222_3333_4444, 8'h0F, 1'b1, 1'b1);
        do_b(RESP_OKAY, 6'd6, 6'd0);
        chk("fixed_addr0", 64'(wr_log[0]), 64'h8);
        chk("fixed_addr1", 64'(wr_log[1]), 64'h8);
        chk("fixed_strb_merge", mem[10'h8], 64'hAAAA_BBBB_3333_4444);

        // INCR read with R stalled: only two SRAM reads may be outstanding.
        rd_log.delete();
        do_ar(6'd9, 32'h100, 8'd3, 3'd3, BURST_INCR, 6'd2);
        issues = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); #1;
            if (mem_req) issues++;
            if (k == 2) chk("r_valid_before_lat", 64'(bus.r_valid), 64'd0);
            if (k == 3) chk("r_valid_at_lat", 64'(bus.r_valid), 64'd1);
        end
        chk("stall_issues", 64'(issues), 64'd2);
        collect_r(4, 3, 6'd9, 6'd2, RESP_OKAY, cyc);
        for (int i = 0; i < 4; i++) begin
            chk("rd_data", (i < r_q.size()) ? r_q[i] : 64'hX, wd[i]);
            chk("rd_addr", (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hX, 64'h20 + 64'(i));
        end
        @(negedge clk); #1;
        chk("r_empty_after_last", 64'(bus.r_valid), 64'd0);

        // WRAP read from 0x118: words 0x23,0x20,0x21,0x22 at one beat per cycle.
        rd_log.delete();
        do_ar(6'd1, 32'h118, 8'd3, 3'd3, BURST_WRAP, 6'd0);
        collect_r(4, 3, 6'd1, 6'd0, RESP_OKAY, cyc);
        chk("wrap_cycles", 64'(cyc), 64'd6);
        for (int i = 0; i < 4; i++)
            chk("wrap_addr", (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hX, 64'(wrap_exp[i]));
        chk("wrap_data0", (r_q.size() > 0) ? r_q[0] : 64'hX, wd[3]);

        // Error bursts: no SRAM traffic, SLVERR responses.
        do_aw(6'd2, 32'h200, 8'd1, 3'd4, BURST_INCR, 6'd1);
        do_w(64'd0, 8'hFF, 1'b0, 1'b0);
        do_w(64'd0, 8'hFF, 1'b1, 1'b0);
        do_b(RESP_SLVERR, 6'd2, 6'd1);
        do_aw(6'd3, 32'h200, 8'd2, 3'd3, BURST_WRAP, 6'd0);
        for (int i = 0; i < 3; i++) do_w(64'd0, 8'hFF, i == 2, 1'b0);
        do_b(RESP_SLVERR, 6'd3, 6'd0);
        do_aw(6'd7, 32'h300, 8'd1, 3'd3, BURST_INCR, 6'd0);
        do_w(64'd0, 8'hFF, 1'b1, 1'b1);
        do_w(64'd0, 8'hFF, 1'b1, 1'b0);
        do_b(RESP_SLVERR, 6'd7, 6'd0);
        rd_log.delete();
        do_ar(6'd4, 32'h100, 8'd1, 3'd4, BURST_INCR, 6'd5);
        collect_r(2, 1, 6'd4, 6'd5, RESP_SLVERR, cyc);
        for (int i = 0; i < 2; i++)
            chk("err_rdata_zero", (i < r_q.size()) ? r_q[i] : 64'hX, 64'd0);
        chk("err_no_mem_read", 64'(rd_log.size()), 64'd0);

        // Reset in the middle of an 8-beat read, then a fresh read.
        do_ar(6'd6, 32'h0, 8'd7, 3'd3, BURST_INCR, 6'd0);
        collect_r(2, 7, 6'd6, 6'd0, RESP_OKAY, cyc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_ar_ready", 64'(bus.ar_ready), 64'd0);
        chk("midrst_aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("midrst_w_ready", 64'(bus.w_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_log.delete();
        do_ar(6'd8, 32'h100, 8'd1, 3'd3, BURST_INCR, 6'd4);
        collect_r(2, 1, 6'd8, 6'd4, RESP_OKAY, cyc);
        chk("postrst_data0", (r_q.size() > 0) ? r_q[0] : 64'hX, wd[0]);
        chk("postrst_data1", (r_q.size() > 1) ? r_q[1] : 64'hX, wd[1]);

        // First AW/AR collision after reset goes to the write.
        @(negedge clk);
        bus.aw_id = 6'd10; bus.aw_addr = 32'h80; bus.aw_len = 8'd0; bus.aw_size = 3'd3;
        bus.aw_burst = BURST_INCR; bus.aw_user = 6'd0; bus.aw_valid = 1'b1;
        bus.ar_id = 6'd11; bus.ar_addr = 32'h100; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
        bus.ar_burst = BURST_INCR; bus.ar_user = 6'd0; bus.ar_valid = 1'b1;
        #1;
        chk("col1_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("col1_ar_ready", 64'(bus.ar_ready), 64'd0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        chk("col1_ar_waits", 64'(bus.ar_ready), 64'd0);
        do_w(64'h5555_6666_7777_8888, 8'hFF, 1'b1, 1'b1);
        do_b(RESP_OKAY, 6'd10, 6'd0);
        do_ar(6'd11, 32'h100, 8'd0, 3'd3, BURST_INCR, 6'd0);
        collect_r(1, 0, 6'd11, 6'd0, RESP_OKAY, cyc);
        chk("col1_rdata", (r_q.size() > 0) ? r_q[0] : 64'hX, wd[0]);

        // Second collision goes to the read.
        @(negedge clk);
        bus.aw_id = 6'd12; bus.aw_addr = 32'h88; bus.aw_valid = 1'b1;
        bus.ar_id = 6'd13; bus.ar_addr = 32'h108; bus.ar_valid = 1'b1;
        #1;
        chk("col2_ar_ready", 64'(bus.ar_ready), 64'd1);
        chk("col2_aw_ready", 64'(bus.aw_ready), 64'd0);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        collect_r(1, 0, 6'd13, 6'd0, RESP_OKAY, cyc);
        chk("col2_rdata", (r_q.size() > 0) ? r_q[0] : 64'hX, wd[1]);
        do_aw(6'd12, 32'h88, 8'd0, 3'd3, BURST_INCR, 6'd0);
        do_w(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1, 1'b1);
        do_b(RESP_OKAY, 6'd12, 6'd0);
        chk("col2_wdata", mem[10'h11], 64'h9999_AAAA_BBBB_CCCC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
